// File: rtl/tx_symbol_upsampler_pkg.sv
// Shared TX definitions: 4-ASK symbol/sample widths, level constants and the Gray symbol map.
package tx_symbol_upsampler_pkg;

  localparam int unsigned SymW    = 2;
  localparam int unsigned SampleW = 18;

  // 1s17 levels; the positive full-scale level saturates one LSB short of +1.0
  localparam logic signed [SampleW-1:0] LevelNeg3 = 18'sh20000;
  localparam logic signed [SampleW-1:0] LevelNeg1 = -18'sd43690;
  localparam logic signed [SampleW-1:0] LevelPos1 = 18'sd43690;
  localparam logic signed [SampleW-1:0] LevelPos3 = 18'sd131071;

  function automatic logic signed [SampleW-1:0] map_symbol(input logic [SymW-1:0] sym);
    logic signed [SampleW-1:0] level;
    unique case (sym)
      2'b00:   level = LevelNeg3;
      2'b01:   level = LevelNeg1;
      2'b11:   level = LevelPos1;
      default: level = LevelPos3;
    endcase
    return level;
  endfunction

endpackage

// File: rtl/tx_symbol_upsampler_sym_fifo.sv
// Small symbol FIFO (sym_fifo) with push/pop and occupancy count; no read bypass.
module tx_symbol_upsampler_sym_fifo
  import tx_symbol_upsampler_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [SymW-1:0]               data_i,
  output logic [SymW-1:0]               data_o,
  output logic [$clog2(Depth+1)-1:0]    count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [SymW-1:0] mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap explicitly so non-power-of-two depths work
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/tx_symbol_upsampler.sv
// 4-ASK symbol upsampler: buffers Gray symbols and emits one mapped sample every OSR clocks,
// zero-stuffed in between, for the TX pulse-shaping filter.
module tx_symbol_upsampler
  import tx_symbol_upsampler_pkg::*;
#(
  parameter int unsigned OSR        = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [SymW-1:0]           sym_in_i,
  input  logic                      sym_valid_i,
  output logic                      sym_ready_o,
  input  logic                      clr_underrun_i,
  output logic signed [SampleW-1:0] x_out_o,
  output logic                      sym_strobe_o,
  output logic                      underrun_o
);

  localparam int unsigned PhW  = $clog2(OSR);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [PhW-1:0]            ph_q, ph_d;
  logic                      primed_q, primed_d;
  logic                      underrun_q, underrun_d;
  logic                      strobe_q, strobe_d;
  logic signed [SampleW-1:0] x_q, x_d;

  logic [CntW-1:0] fifo_count;
  logic [SymW-1:0] fifo_head;
  logic            fifo_empty, fifo_full, slot, push, pop;

  tx_symbol_upsampler_sym_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_sym_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (sym_in_i),
    .data_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign fifo_empty  = (fifo_count == '0);
  assign fifo_full   = (fifo_count == CntW'(FIFO_DEPTH));
  // Ready comes from registered occupancy only, so a pop cannot reopen a full FIFO same-cycle
  assign sym_ready_o = ~rst_i & ~fifo_full;
  assign push        = sym_valid_i & sym_ready_o;
  assign slot        = (ph_q == '0);
  assign pop         = slot & ~fifo_empty;

  always_comb begin
    ph_d       = (ph_q == PhW'(OSR - 1)) ? '0 : ph_q + 1'b1;
    primed_d   = primed_q | pop;
    strobe_d   = pop;
    x_d        = pop ? map_symbol(fifo_head) : '0;
    underrun_d = underrun_q;
    if (slot && fifo_empty && primed_q) begin
      underrun_d = 1'b1;
    end else if (clr_underrun_i) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ph_q       <= '0;
      primed_q   <= 1'b0;
      underrun_q <= 1'b0;
      strobe_q   <= 1'b0;
      x_q        <= '0;
    end else begin
      ph_q       <= ph_d;
      primed_q   <= primed_d;
      underrun_q <= underrun_d;
      strobe_q   <= strobe_d;
      x_q        <= x_d;
    end
  end

  assign x_out_o      = x_q;
  assign sym_strobe_o = strobe_q;
  assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_tx_symbol_upsampler.sv
// Self-checking bench for tx_symbol_upsampler: a negedge scoreboard plus scenario tasks.
`timescale 1ns/1ps
module tb_tx_symbol_upsampler;

  localparam int unsigned OSR   = 4;
  localparam int unsigned DEPTH = 2;

  typedef logic signed [31:0] lvl_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        sym_in = 2'b00;
  logic              sym_valid = 1'b0;
  logic              clr_underrun = 1'b0;
  logic              sym_ready;
  logic signed [17:0] x_out;
  logic              sym_strobe;
  logic              underrun;

  int checks = 0;
  int errors = 0;
  int n_strobe = 0;

  // Scoreboard / reference state
  int   m_ph;
  lvl_t m_q[$];
  lvl_t m_exp_x;
  logic m_exp_strobe, m_exp_und, m_primed;
  logic slot, empty, mready;

  tx_symbol_upsampler #(
    .OSR        (OSR),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sym_in_i       (sym_in),
    .sym_valid_i    (sym_valid),
    .sym_ready_o    (sym_ready),
    .clr_underrun_i (clr_underrun),
    .x_out_o        (x_out),
    .sym_strobe_o   (sym_strobe),
    .underrun_o     (underrun)
  );

  always #5 clk = ~clk;

  function automatic lvl_t tb_map(input logic [1:0] s);
    case (s)
      2'b00:   return -131072;
      2'b01:   return -43690;
      2'b11:   return 43690;
      default: return 131071;
    endcase
  endfunction

  // Scoreboard: compare outputs, then predict the effect of the coming clock edge
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        checks++;
        if (x_out !== 18'sd0 || sym_strobe !== 1'b0 || underrun !== 1'b0 || sym_ready !== 1'b0) begin
          errors++;
          $display("FAIL reset_hold: x_out=%0d strobe=%b underrun=%b ready=%b, required all 0",
                   x_out, sym_strobe, underrun, sym_ready);
        end
        m_ph = 0; m_q.delete(); m_exp_x = 0; m_exp_strobe = 0; m_exp_und = 0; m_primed = 0;
      end else begin
        mready = (m_q.size() < DEPTH);
        checks++;
        if (x_out !== m_exp_x[17:0] || sym_strobe !== m_exp_strobe || underrun !== m_exp_und) begin
          errors++;
          $display("FAIL sb_outputs @%0t: x_out=%0d strobe=%b underrun=%b, required %0d %b %b",
                   $time, x_out, sym_strobe, underrun, m_exp_x, m_exp_strobe, m_exp_und);
        end
        checks++;
        if (sym_ready !== mready) begin
          errors++;
          $display("FAIL sb_ready @%0t: ready=%b, required %b", $time, sym_ready, mready);
        end
        if (sym_strobe === 1'b1) n_strobe++;
        slot  = (m_ph == 0);
        empty = (m_q.size() == 0);
        if (slot && empty && m_primed) m_exp_und = 1'b1;
        else if (clr_underrun) m_exp_und = 1'b0;
        if (slot && !empty) begin
          m_exp_x = m_q.pop_front(); m_exp_strobe = 1'b1; m_primed = 1'b1;
        end else begin
          m_exp_x = 0; m_exp_strobe = 1'b0;
        end
        if (sym_valid && mready) m_q.push_back(tb_map(sym_in));
        m_ph = (m_ph + 1) % OSR;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    sym_valid = 1'b0; clr_underrun = 1'b0;
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
  endtask

  // Holds sym_valid until the symbol is accepted; leaves sym_valid high on return
  task automatic push_sym(input logic [1:0] s);
    logic acc;
    int k;
    sym_in = s; sym_valid = 1'b1; k = 0;
    do begin
      @(negedge clk); acc = sym_ready; @(posedge clk); #1; k++;
    end while (!acc && k < 50);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL push_timeout: symbol %b not accepted within %0d cycles", s, k);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (x_out !== 18'sd0 || sym_strobe !== 1'b0 || underrun !== 1'b0 || sym_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: x_out=%0d strobe=%b underrun=%b ready=%b before any edge, required 0",
               x_out, sym_strobe, underrun, sym_ready);
    end
    tick(); tick();
    rst = 1'b0; #1;
    checks++;
    if (sym_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: ready=%b, required 1", sym_ready);
    end
  endtask

  task automatic test_idle();
    int bad;
    do_reset(); bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (x_out !== 18'sd0 || sym_strobe !== 1'b0 || underrun !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_quiet: %0d non-quiet cycles, required 0", bad);
    end
  endtask

  task automatic test_sequence();
    lvl_t exp_seq [16];
    exp_seq = '{131071, 0, 0, 0, -131072, 0, 0, 0, -43690, 0, 0, 0, 43690, 0, 0, 0};
    do_reset();
    fork
      begin
        push_sym(2'b10); push_sym(2'b00); push_sym(2'b01); push_sym(2'b11);
        sym_valid = 1'b0;
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (sym_strobe !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        checks++;
        if (w >= 50) begin
          errors++;
          $display("FAIL seq_first_strobe: no strobe in %0d cycles, required one", w);
        end else begin
          for (int i = 0; i < 16; i++) begin
            checks++;
            if (x_out !== exp_seq[i][17:0] || sym_strobe !== (i % 4 == 0) || underrun !== 1'b0) begin
              errors++;
              $display("FAIL seq_sample[%0d]: x_out=%0d strobe=%b underrun=%b, required %0d %b 0",
                       i, x_out, sym_strobe, underrun, exp_seq[i], (i % 4 == 0));
            end
            @(negedge clk);
          end
        end
      end
    join
  endtask

  task automatic test_underrun();
    int n;
    do_reset();
    push_sym(2'b01); sym_valid = 1'b0;
    n = 0; @(negedge clk);
    while (sym_strobe !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n = 0; @(negedge clk);
    while (underrun !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n != OSR - 1) begin
      errors++;
      $display("FAIL underrun_delay: set %0d cycles after strobe, required %0d", n + 1, OSR);
    end
    @(posedge clk); #1;
    clr_underrun = 1'b1; tick(); clr_underrun = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear: underrun=%b, required 0", underrun);
    end
    n = 0; @(negedge clk);
    while (underrun !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL underrun_reset_slot: re-set after %0d cycles, required 2", n);
    end
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    clr_underrun = 1'b1; tick(); clr_underrun = 1'b0;
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_set_wins: underrun=%b, required 1", underrun);
    end
  endtask

  task automatic test_back_to_back();
    bit rdy [64];
    int pushes, s0, hi;
    do_reset();
    s0 = n_strobe; pushes = 0; hi = 0;
    sym_in = 2'($urandom_range(0, 3)); sym_valid = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk); rdy[c] = sym_ready;
      @(posedge clk); #1;
      if (rdy[c]) begin pushes++; sym_in = 2'($urandom_range(0, 3)); end
    end
    sym_valid = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_underrun: underrun=%b, required 0", underrun);
    end
    checks++;
    if (!(rdy[0] && rdy[1] && !rdy[2] && !rdy[3] && !rdy[4] && rdy[5])) begin
      errors++;
      $display("FAIL b2b_ready_start: ready=%b%b%b%b%b%b, required 110001",
               rdy[0], rdy[1], rdy[2], rdy[3], rdy[4], rdy[5]);
    end
    for (int c = 16; c < 32; c++) if (rdy[c]) hi++;
    checks++;
    if (hi != 4) begin
      errors++;
      $display("FAIL b2b_ready_rate: %0d ready cycles in 16, required 4", hi);
    end
    repeat (4 * OSR) tick();
    checks++;
    if (n_strobe - s0 != pushes) begin
      errors++;
      $display("FAIL b2b_count: %0d strobes, required %0d", n_strobe - s0, pushes);
    end
  endtask

  task automatic test_async_reset();
    int n, s0;
    do_reset();
    push_sym(2'b10); push_sym(2'b11); push_sym(2'b00);
    sym_valid = 1'b0; #1;
    rst = 1'b1; #1;
    checks++;
    if (x_out !== 18'sd0 || sym_strobe !== 1'b0 || underrun !== 1'b0 || sym_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_mid: x_out=%0d strobe=%b underrun=%b ready=%b, required 0",
               x_out, sym_strobe, underrun, sym_ready);
    end
    tick(); tick(); rst = 1'b0;
    s0 = n_strobe;
    repeat (3 * OSR) tick();
    checks++;
    if (n_strobe != s0) begin
      errors++;
      $display("FAIL async_discard: %0d strobes from stale symbols, required 0", n_strobe - s0);
    end
    push_sym(2'b01); sym_valid = 1'b0;
    n = 0; @(negedge clk);
    while (sym_strobe !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (x_out !== -18'sd43690) begin
      errors++;
      $display("FAIL async_first_sample: x_out=%0d, required -43690", x_out);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    test_reset();
    test_idle();
    test_sequence();
    test_underrun();
    test_back_to_back();
    test_async_reset();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
